// File: rtl/rx_sample_serializer.sv
// rx_sample_serializer: pops SAMPLE_W-bit samples from an AXI-stream FIFO port
// and emits them as OUT_W-bit words, one per rd_req pulse. It also provides a
// hysteretic samples-available flag and sticky/saturating underrun status.
module rx_sample_serializer #(
  parameter int unsigned SAMPLE_W  = 24,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned AVAIL_HI  = 256,
  parameter int unsigned AVAIL_LO  = 192,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned UCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  input  logic [LEN_W-1:0]    s_tlength,
  input  logic                rd_req,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic                samples_avail,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  input  logic                clr_status
);

  localparam int unsigned NW   = SAMPLE_W / OUT_W;
  localparam int unsigned WL_W = $clog2(NW + 1);

  localparam logic [LEN_W-1:0] LEN_HI = LEN_W'(AVAIL_HI);
  localparam logic [LEN_W-1:0] LEN_LO = LEN_W'(AVAIL_LO);
  localparam logic [WL_W-1:0]  WL_NW  = WL_W'(NW);
  localparam logic [WL_W-1:0]  WL_ONE = WL_W'(1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SAMPLE_W-1:0] r_sr;
  logic [SAMPLE_W-1:0] w_sr_nxt;
  logic [WL_W-1:0]     r_wl;
  logic [WL_W-1:0]     w_wl_nxt;
  logic                r_hl;
  logic                w_hl_nxt;

  logic [OUT_W-1:0]    w_out_data_nxt;
  logic                w_out_valid_nxt;
  logic                w_out_last_nxt;
  logic                w_underrun_nxt;
  logic [UCNT_W-1:0]   w_ucnt_nxt;
  logic                w_avail_nxt;

  logic [OUT_W-1:0]    w_word;
  logic [SAMPLE_W-1:0] w_sr_shift;
  logic                w_last_word;

  // Word at the emitting end of the shift register, and the register after it leaves
  assign w_word      = (MSB_FIRST != 0) ? r_sr[SAMPLE_W-1 -: OUT_W] : r_sr[OUT_W-1:0];
  assign w_sr_shift  = (MSB_FIRST != 0) ? (r_sr << OUT_W) : (r_sr >> OUT_W);
  assign w_last_word = (r_wl == WL_ONE);

  // FIFO pop: always ready when empty, or when the final word leaves on this request
  assign s_tready = (r_state == ST_EMPTY) ||
                    ((r_state == ST_HOLD) && rd_req && w_last_word);

  // Next-state, datapath and status logic
  always_comb begin
    w_state_nxt     = r_state;
    w_sr_nxt        = r_sr;
    w_wl_nxt        = r_wl;
    w_hl_nxt        = r_hl;
    w_out_data_nxt  = out_data;
    w_out_valid_nxt = out_valid;
    w_out_last_nxt  = out_last;
    w_underrun_nxt  = underrun;
    w_ucnt_nxt      = underrun_cnt;
    w_avail_nxt     = samples_avail;

    case (r_state)
      ST_EMPTY: begin
        // Prefetch: the first word is served from HOLD on a later request
        if (s_tvalid) begin
          w_sr_nxt    = s_tdata;
          w_hl_nxt    = s_tlast;
          w_wl_nxt    = WL_NW;
          w_state_nxt = ST_HOLD;
        end
        // Any request seen while empty is an underrun, even on the accept cycle
        if (rd_req) begin
          w_out_data_nxt  = '0;
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_underrun_nxt  = 1'b1;
          if (!(&underrun_cnt)) begin
            w_ucnt_nxt = underrun_cnt + UCNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (rd_req) begin
          w_out_data_nxt  = w_word;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = w_last_word && r_hl;
          w_sr_nxt        = w_sr_shift;
          w_wl_nxt        = r_wl - WL_ONE;
          if (w_last_word) begin
            // Back-to-back reload keeps the word stream gapless
            if (s_tvalid) begin
              w_sr_nxt = s_tdata;
              w_hl_nxt = s_tlast;
              w_wl_nxt = WL_NW;
            end else begin
              w_state_nxt = ST_EMPTY;
            end
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    // Clear wins over a same-cycle underrun
    if (clr_status) begin
      w_underrun_nxt = 1'b0;
      w_ucnt_nxt     = '0;
    end

    // Hysteresis between the two fill thresholds
    if (s_tlength >= LEN_HI) begin
      w_avail_nxt = 1'b1;
    end else if (s_tlength <= LEN_LO) begin
      w_avail_nxt = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      r_sr          <= '0;
      r_wl          <= '0;
      r_hl          <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      samples_avail <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sr          <= w_sr_nxt;
      r_wl          <= w_wl_nxt;
      r_hl          <= w_hl_nxt;
      out_data      <= w_out_data_nxt;
      out_valid     <= w_out_valid_nxt;
      out_last      <= w_out_last_nxt;
      underrun      <= w_underrun_nxt;
      underrun_cnt  <= w_ucnt_nxt;
      samples_avail <= w_avail_nxt;
    end
  end

endmodule
